// File: rtl/inst_mem_responder.sv
// Instruction-side main memory: answers word reads from the instruction cache after
// READ_LATENCY cycles, returning big-endian words from a byte store loaded via a preload port.
module inst_mem_responder #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_LEN     = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_vis_addr,
  input  logic [1:0]            mem_vis_signal,
  output logic [DATA_LEN-1:0]   mem_data,
  output logic [1:0]            mem_status,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [BYTE_SIZE-1:0]  load_byte
);

  localparam logic [1:0] MEM_READ          = 2'b01;
  localparam logic [1:0] MEM_RESTING       = 2'b00;
  localparam logic [1:0] MEM_WORKING       = 2'b01;
  localparam logic [1:0] MEM_INST_FINISHED = 2'b10;

  localparam logic [3:0]            LAT_M1   = 4'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Handshake: the cache holds MEM_READ (address sampled only at acceptance) until it
  // sees MEM_INST_FINISHED for exactly one cycle; dropping MEM_READ while busy aborts.
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              status_q, status_d;
  logic [DATA_LEN-1:0]     data_q, data_d;

  logic [BYTE_SIZE-1:0]    mem [0:(1<<ADDR_WIDTH)-1];

  logic                    rd_req;
  logic [ADDR_WIDTH-1:0]   addr_p1, addr_p2, addr_p3;
  logic [DATA_LEN-1:0]     rd_word;

  assign rd_req = (mem_vis_signal == MEM_READ);

  // Byte addresses wrap naturally modulo 2^ADDR_WIDTH.
  assign addr_p1 = addr_q + ADDR_ONE;
  assign addr_p2 = addr_p1 + ADDR_ONE;
  assign addr_p3 = addr_p2 + ADDR_ONE;
  assign rd_word = {mem[addr_q], mem[addr_p1], mem[addr_p2], mem[addr_p3]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    status_d = status_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          addr_d   = mem_vis_addr;
          cnt_d    = LAT_M1;
          state_d  = S_BUSY;
          status_d = MEM_WORKING;
        end else begin
          status_d = MEM_RESTING;
        end
      end
      S_BUSY: begin
        if (!rd_req) begin
          state_d  = S_IDLE;
          status_d = MEM_RESTING;
        end else if (cnt_q == 4'd0) begin
          state_d  = S_DONE;
          status_d = MEM_INST_FINISHED;
          data_d   = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // A request seen during the finished cycle is only sampled again from IDLE.
        state_d  = S_IDLE;
        status_d = MEM_RESTING;
      end
      default: begin
        state_d  = S_IDLE;
        status_d = MEM_RESTING;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      status_q <= MEM_RESTING;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      data_q   <= data_d;
    end
  end

  // Storage is not reset; reads above see the pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_byte;
    end
  end

  assign mem_data   = data_q;
  assign mem_status = status_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: latency-3 instance for most scenarios, latency-1 instance
// for the wrap-around read; completed words are checked against an expected queue.
module tb_inst_mem_responder;

  localparam int AW = 17;
  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] READ = 2'b01;
  localparam logic [1:0] ST_REST = 2'b00;
  localparam logic [1:0] ST_WORK = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  logic          clk;
  logic          rst;
  logic [AW-1:0] mem_vis_addr, load_addr;
  logic [1:0]    mem_vis_signal;
  logic [31:0]   mem_data;
  logic [1:0]    mem_status;
  logic          load_en;
  logic [7:0]    load_byte;

  logic [AW-1:0] mem_vis_addr_1, load_addr_1;
  logic [1:0]    mem_vis_signal_1;
  logic [31:0]   mem_data_1;
  logic [1:0]    mem_status_1;
  logic          load_en_1;
  logic [7:0]    load_byte_1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  shadow [0:(1<<AW)-1];

  inst_mem_responder #(.ADDR_WIDTH(AW), .DATA_LEN(32), .BYTE_SIZE(8), .READ_LATENCY(3)) u_dut (
    .clk(clk), .rst(rst), .mem_vis_addr(mem_vis_addr), .mem_vis_signal(mem_vis_signal),
    .mem_data(mem_data), .mem_status(mem_status), .load_en(load_en),
    .load_addr(load_addr), .load_byte(load_byte)
  );

  inst_mem_responder #(.ADDR_WIDTH(AW), .DATA_LEN(32), .BYTE_SIZE(8), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_vis_addr(mem_vis_addr_1), .mem_vis_signal(mem_vis_signal_1),
    .mem_data(mem_data_1), .mem_status(mem_status_1), .load_en(load_en_1),
    .load_addr(load_addr_1), .load_byte(load_byte_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: every finished word on the latency-3 instance must be expected
  always @(negedge clk) begin
    if (!rst && mem_status == ST_FIN) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_finish: got data %h with no expected word", mem_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (mem_data !== e) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", mem_data, e);
        end
      end
    end
  end

  // driver tasks (called from negedge context)
  task automatic preload(input logic [AW-1:0] a, input logic [7:0] b);
    load_en = 1'b1; load_addr = a; load_byte = b;
    shadow[a] = b;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic preload1(input logic [AW-1:0] a, input logic [7:0] b);
    load_en_1 = 1'b1; load_addr_1 = a; load_byte_1 = b;
    @(negedge clk);
    load_en_1 = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
    logic [AW-1:0] a1, a2, a3;
    a1 = a + AW'(1); a2 = a1 + AW'(1); a3 = a2 + AW'(1);
    return {shadow[a], shadow[a1], shadow[a2], shadow[a3]};
  endfunction

  task automatic chk_status(input string name, input logic [1:0] exp);
    checks++;
    if (mem_status !== exp) begin
      errors++;
      $display("FAIL %s: status got %b expected %b", name, mem_status, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [31:0] exp);
    checks++;
    if (mem_data !== exp) begin
      errors++;
      $display("FAIL %s: data got %h expected %h", name, mem_data, exp);
    end
  endtask

  task automatic wait_finish(input string name);
    int n;
    n = 0;
    while (mem_status !== ST_FIN && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_status !== ST_FIN) begin
      errors++;
      $display("FAIL %s: timeout, status %b expected %b", name, mem_status, ST_FIN);
    end
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1;
    mem_vis_signal = NOP; mem_vis_addr = '0; load_en = 1'b0; load_addr = '0; load_byte = '0;
    mem_vis_signal_1 = NOP; mem_vis_addr_1 = '0; load_en_1 = 1'b0; load_addr_1 = '0; load_byte_1 = '0;
    repeat (2) @(negedge clk);
    chk_status("reset_status", ST_REST);
    chk_data("reset_data", 32'h0);
    checks++;
    if (mem_status_1 !== ST_REST || mem_data_1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut1: status %b data %h expected 00 and 0", mem_status_1, mem_data_1);
    end
    rst = 1'b0;
    @(negedge clk);
    chk_status("idle_after_reset", ST_REST);
  endtask

  task automatic test_basic;
    preload(17'h100, 8'h13); preload(17'h101, 8'h05);
    preload(17'h102, 8'h10); preload(17'h103, 8'h00);
    preload(17'h104, 8'h93); preload(17'h105, 8'h00);
    preload(17'h106, 8'h00); preload(17'h107, 8'h00);
    mem_vis_signal = READ; mem_vis_addr = 17'h100;
    exp_q.push_back(32'h13051000);
    @(negedge clk); chk_status("basic_e0", ST_WORK);
    mem_vis_addr = 17'h200;
    @(negedge clk); chk_status("basic_e1", ST_WORK);
    @(negedge clk); chk_status("basic_e2", ST_WORK);
    @(negedge clk); chk_status("basic_done", ST_FIN);
    chk_data("basic_data", 32'h13051000);
  endtask

  task automatic test_back_to_back;
    mem_vis_addr = 17'h104;
    exp_q.push_back(32'h93000000);
    @(negedge clk); chk_status("b2b_not_accepted_in_done", ST_REST);
    chk_data("b2b_data_held", 32'h13051000);
    @(negedge clk); chk_status("b2b_accept", ST_WORK);
    @(negedge clk); chk_status("b2b_e6", ST_WORK);
    @(negedge clk); chk_status("b2b_e7", ST_WORK);
    @(negedge clk); chk_status("b2b_done", ST_FIN);
    chk_data("b2b_data", 32'h93000000);
    mem_vis_signal = NOP;
    @(negedge clk); chk_status("b2b_rest", ST_REST);
  endtask

  task automatic test_abort;
    mem_vis_signal = READ; mem_vis_addr = 17'h100;
    @(negedge clk); chk_status("abort_e0", ST_WORK);
    @(negedge clk);
    @(negedge clk); chk_status("abort_e2", ST_WORK);
    mem_vis_signal = NOP;
    @(negedge clk); chk_status("abort_status", ST_REST);
    chk_data("abort_data_hold", 32'h93000000);
    repeat (3) begin
      @(negedge clk); chk_status("abort_quiet", ST_REST);
    end
  endtask

  task automatic test_preload_race;
    mem_vis_signal = READ; mem_vis_addr = 17'h100;
    exp_q.push_back(32'h13051000);
    repeat (3) @(negedge clk);
    load_en = 1'b1; load_addr = 17'h100; load_byte = 8'hFF;
    shadow[17'h100] = 8'hFF;
    @(negedge clk);
    load_en = 1'b0;
    chk_status("race_done", ST_FIN);
    chk_data("race_old_byte", 32'h13051000);
    mem_vis_signal = NOP;
    @(negedge clk);
    mem_vis_signal = READ; mem_vis_addr = 17'h100;
    exp_q.push_back(32'hFF051000);
    @(negedge clk);
    wait_finish("race_repeat_wait");
    chk_data("race_new_byte", 32'hFF051000);
    mem_vis_signal = NOP;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [AW-1:0] base, a;
    logic [31:0] e;
    for (int it = 0; it < 5; it++) begin
      base = (it == 4) ? 17'h1FFFC : AW'($urandom_range(17'h400, 17'h1F000));
      for (int k = 0; k < 8; k++) preload(base + AW'(k), 8'($urandom_range(0, 255)));
      a = base + AW'($urandom_range(0, 4));
      e = exp_word(a);
      mem_vis_signal = READ; mem_vis_addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      wait_finish("rand_wait");
      chk_data("rand_data", e);
      mem_vis_signal = NOP;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    mem_vis_signal = READ; mem_vis_addr = 17'h104;
    @(negedge clk);
    @(negedge clk); chk_status("midrst_busy", ST_WORK);
    #2 rst = 1'b1;
    #1;
    chk_status("rst_async_status", ST_REST);
    chk_data("rst_async_data", 32'h0);
    @(negedge clk);
    mem_vis_signal = NOP;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk); chk_status("midrst_no_finish", ST_REST);
    end
  endtask

  task automatic test_wrap_lat1;
    preload1(17'h1FFFE, 8'hAA); preload1(17'h1FFFF, 8'hBB);
    preload1(17'h00000, 8'hCC); preload1(17'h00001, 8'hDD);
    mem_vis_signal_1 = READ; mem_vis_addr_1 = 17'h1FFFE;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_status_1 !== ST_FIN) begin
      errors++;
      $display("FAIL lat1_finish: status %b expected %b", mem_status_1, ST_FIN);
    end
    checks++;
    if (mem_data_1 !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL lat1_wrap_data: got %h expected %h", mem_data_1, 32'hAABBCCDD);
    end
    mem_vis_signal_1 = NOP;
    @(negedge clk);
    checks++;
    if (mem_status_1 !== ST_REST) begin
      errors++;
      $display("FAIL lat1_rest: status %b expected %b", mem_status_1, ST_REST);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_preload_race();
    test_random();
    test_reset_mid();
    test_wrap_lat1();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d words left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
